// File: rtl/spi_frame_tx_if.sv
// Request channel into spi_frame_tx.
//   req_valid  requester has a transaction
//   req_ready  transmitter can accept this cycle
//   req_type   0=start, 1=cfg, 2=read, 3=raw
//   req_head   header byte used only for raw transactions
//   req_data   payload bits, sent LSB first (cfg uses [7:0], read uses [9:0])
interface spi_frame_tx_if;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_type;
   logic [7:0] req_head;
   logic [9:0] req_data;

   modport master (
      output req_valid, req_type, req_head, req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_type, req_head, req_data,
      output req_ready
   );
endinterface

// File: rtl/spi_frame_tx.sv
// Transmit side of the frame/serial/suspend link. Takes one request at a time and
// sends: one lead cycle (frame=1, serial=0), an 8-bit header LSB first, a type-dependent
// payload LSB first, then one gap cycle with frame low and a done pulse. A flow-control
// suspend output is generated from susp_req; while suspend is high the frame engine holds.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   req       request channel (slave side)
//   susp_req  upstream asks for a suspend cycle
//   frame     frame strobe to link
//   serial    serial data to link
//   suspend   link suspend (never more than SUSP_MAX cycles in a row)
//   busy      a frame is in progress
//   done      one-cycle pulse in the gap cycle
module spi_frame_tx #(
   parameter logic [7:0]  HDR_START = 8'hA5,
   parameter logic [7:0]  HDR_CFG   = 8'hC3,
   parameter logic [7:0]  HDR_READ  = 8'h3C,
   parameter int unsigned SUSP_MAX  = 3
) (
   input  logic          clk,
   input  logic          rst,
   spi_frame_tx_if.slave req,
   input  logic          susp_req,
   output logic          frame,
   output logic          serial,
   output logic          suspend,
   output logic          busy,
   output logic          done
);

   localparam logic [1:0] SuspMax = 2'(SUSP_MAX);

   typedef enum logic [2:0] {StIdle, StLead, StHead, StBody, StGap} state_e;

   state_e     state_q, state_d;
   logic [7:0] hdr_q, hdr_d;
   logic [9:0] data_q, data_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] body_len_q, body_len_d;
   logic       frame_q, frame_d;
   logic       serial_q, serial_d;
   logic       done_q, done_d;
   logic       suspend_q, suspend_d;
   logic [1:0] susp_cnt_q, susp_cnt_d;
   logic       ready;

   assign ready         = (state_q == StIdle) && !suspend_q;
   assign req.req_ready = ready;

   // Compare against the count including this cycle so the run stops at SuspMax highs.
   always_comb begin
      susp_cnt_d = suspend_q ? susp_cnt_q + 2'd1 : 2'd0;
      suspend_d  = susp_req && (susp_cnt_d < SuspMax);
   end

   always_comb begin
      state_d    = state_q;
      hdr_d      = hdr_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      body_len_d = body_len_q;
      frame_d    = frame_q;
      serial_d   = serial_q;
      done_d     = done_q;
      if (!suspend_q) begin
         done_d = 1'b0;
         unique case (state_q)
            StIdle: begin
               frame_d  = 1'b0;
               serial_d = 1'b0;
               if (req.req_valid) begin
                  state_d = StLead;
                  frame_d = 1'b1;
                  data_d  = req.req_data;
                  cnt_d   = 4'd0;
                  unique case (req.req_type)
                     2'd0: begin hdr_d = HDR_START;    body_len_d = 4'd0;  end
                     2'd1: begin hdr_d = HDR_CFG;      body_len_d = 4'd8;  end
                     2'd2: begin hdr_d = HDR_READ;     body_len_d = 4'd10; end
                     default: begin hdr_d = req.req_head; body_len_d = 4'd0; end
                  endcase
               end
            end
            StLead: begin
               state_d  = StHead;
               serial_d = hdr_q[0];
               hdr_d    = hdr_q >> 1;
               cnt_d    = 4'd7;
            end
            // cnt_q holds the number of bits still to send in the current phase.
            StHead: begin
               if (cnt_q != 4'd0) begin
                  serial_d = hdr_q[0];
                  hdr_d    = hdr_q >> 1;
                  cnt_d    = cnt_q - 4'd1;
               end else if (body_len_q != 4'd0) begin
                  state_d  = StBody;
                  serial_d = data_q[0];
                  data_d   = data_q >> 1;
                  cnt_d    = body_len_q - 4'd1;
               end else begin
                  state_d  = StGap;
                  frame_d  = 1'b0;
                  serial_d = 1'b0;
                  done_d   = 1'b1;
               end
            end
            StBody: begin
               if (cnt_q != 4'd0) begin
                  serial_d = data_q[0];
                  data_d   = data_q >> 1;
                  cnt_d    = cnt_q - 4'd1;
               end else begin
                  state_d  = StGap;
                  frame_d  = 1'b0;
                  serial_d = 1'b0;
                  done_d   = 1'b1;
               end
            end
            StGap: begin
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         hdr_q      <= 8'd0;
         data_q     <= 10'd0;
         cnt_q      <= 4'd0;
         body_len_q <= 4'd0;
         frame_q    <= 1'b0;
         serial_q   <= 1'b0;
         done_q     <= 1'b0;
         suspend_q  <= 1'b0;
         susp_cnt_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         hdr_q      <= hdr_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         body_len_q <= body_len_d;
         frame_q    <= frame_d;
         serial_q   <= serial_d;
         done_q     <= done_d;
         suspend_q  <= suspend_d;
         susp_cnt_q <= susp_cnt_d;
      end
   end

   assign frame   = frame_q;
   assign serial  = serial_q;
   assign suspend = suspend_q;
   assign busy    = (state_q != StIdle);
   // The gap may land on a suspended cycle; the pulse shows in its non-suspended cycle.
   assign done    = done_q && !suspend_q;

endmodule
